// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
// The master side drives enable and divisor loads; the slave side is the divider.
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_val;
    logic             div_load;
    logic             div_ack;
    logic             clk_out;
    logic             tick;
    logic             err;

    modport master (
        output en, div_val, div_load,
        input  div_ack, clk_out, tick, err
    );

    modport slave (
        input  en, div_val, div_load,
        output div_ack, clk_out, tick, err
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider.
// Produces a registered divided clock (ceil(D/2) high, floor(D/2) low) plus a
// tick strobe at the start of each high phase. A new divisor is queued and only
// takes effect at a period boundary, so periods are never cut short or
// stretched except by en deassertion or rst.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    clk_div_prog_if.slave      bus
);

    localparam int MAX_DIV = (1 << WIDTH) - 1;

    // Reject an unusable reset divisor when the design is elaborated.
    if (DEFAULT_DIV < 2 || DEFAULT_DIV > MAX_DIV) begin : g_bad_default_div
        $error("clk_div_prog: DEFAULT_DIV must be in 2..2^WIDTH-1");
    end

    typedef enum logic {
        ST_STOP,
        ST_RUN
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cur_div_q;
    logic [WIDTH-1:0] pend_div_q;
    logic             pend_valid_q;
    logic             clk_out_q;
    logic             tick_q;
    logic             div_ack_q;
    logic             err_q;

    logic             load_bad;
    logic [WIDTH-1:0] load_div;
    logic [WIDTH-1:0] pend_div_d;
    logic             pend_valid_d;
    logic             at_wrap;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] high_cnt;
    logic             apply;

    // Divisors below 2 cannot produce a clock; clamp them and flag the error.
    assign load_bad = bus.div_load && (bus.div_val < WIDTH'(2));
    assign load_div = (bus.div_val < WIDTH'(2)) ? WIDTH'(2) : bus.div_val;

    // A load in this cycle bypasses the pending register so it can apply at
    // this very edge; a later load simply overwrites an earlier one.
    assign pend_div_d   = bus.div_load ? load_div : pend_div_q;
    assign pend_valid_d = bus.div_load | pend_valid_q;

    // cnt_q always stays below cur_div_q because the divisor only changes at
    // a wrap or while stopped, so cnt_q + 1 can never overflow WIDTH bits.
    assign at_wrap  = (cnt_q == cur_div_q - WIDTH'(1));
    assign cnt_d    = at_wrap ? '0 : cnt_q + WIDTH'(1);
    assign high_cnt = cur_div_q - (cur_div_q >> 1);

    // Period boundary: any edge while stopped (including the start edge) or
    // the wrap edge of a running period.
    assign apply = pend_valid_d && ((state_q == ST_STOP) || (bus.en && at_wrap));

    // Run/stop FSM with all outputs and divisor bookkeeping registered.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_STOP;
            cnt_q        <= '0;
            cur_div_q    <= WIDTH'(DEFAULT_DIV);
            pend_div_q   <= WIDTH'(DEFAULT_DIV);
            pend_valid_q <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            div_ack_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (load_bad) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                ST_STOP: begin
                    if (bus.en) begin
                        state_q   <= ST_RUN;
                        cnt_q     <= '0;
                        clk_out_q <= 1'b1;
                        tick_q    <= 1'b1;
                    end else begin
                        cnt_q     <= '0;
                        clk_out_q <= 1'b0;
                        tick_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.en) begin
                        cnt_q     <= cnt_d;
                        clk_out_q <= (cnt_d < high_cnt);
                        tick_q    <= (cnt_d == '0);
                    end else begin
                        // Stop is immediate; the running period is truncated.
                        state_q   <= ST_STOP;
                        cnt_q     <= '0;
                        clk_out_q <= 1'b0;
                        tick_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_STOP;
                end
            endcase

            if (apply) begin
                cur_div_q    <= pend_div_d;
                pend_valid_q <= 1'b0;
                div_ack_q    <= 1'b1;
            end else begin
                pend_div_q   <= pend_div_d;
                pend_valid_q <= pend_valid_d;
                div_ack_q    <= 1'b0;
            end
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.div_ack = div_ack_q;
    assign bus.err     = err_q;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised, programmable integer clock divider; successor to the fixed divide-by-2 toggle generator.
- Produces a registered divided clock, `clk_out`, from `clk` with a run-time divisor, enable control, glitch-free divisor change at period boundaries, and a rising-edge tick strobe.
- `clk_out` is intended as a generated-clock source for SmartTime constraint demos; `tick` is the clock-enable form for same-domain logic.

Parameters:
- WIDTH, 8, bit width of divisor and internal counter; divisor range 2..2^WIDTH-1.
- DEFAULT_DIV, 2, divisor active after reset; must be >= 2 and < 2^WIDTH (elaboration error otherwise).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; low = divider stopped, `clk_out` held low.
- div_val  input  WIDTH  requested divisor D.
- div_load  input  1  one-cycle request to latch `div_val`.
- div_ack  output  1  one-cycle pulse at the edge the new divisor becomes active.
- clk_out  output  1  divided clock, flop output.
- tick  output  1  one-cycle pulse coincident with each `clk_out` rising phase start.
- err  output  1  sticky: an illegal divisor (<2) was loaded.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - cnt=0, running=0, cur_div=DEFAULT_DIV, pend_valid=0.
  - clk_out=0, tick=0, div_ack=0, err=0.
  - rst overrides all other inputs, including a pending load.
- Definitions: D=cur_div; H=D-(D>>1), i.e. ceil(D/2) high cycles; D-H low cycles; period D cycles.
- Start (edge with en=1, running=0):
  - running<=1, cnt<=0, clk_out<=1, tick<=1.
- Run (edge with en=1, running=1):
  - cnt<=(cnt==D-1)?0:cnt+1.
  - clk_out<=(cnt_next<H).
  - tick<=(cnt_next==0).
  - Wrap edge = the edge where cnt goes D-1 -> 0.
- Stop (edge with en=0):
  - running<=0, cnt<=0, clk_out<=0, tick<=0.
  - The stop is immediate; the current period is truncated.
  - Re-enable restarts with a full high phase.
- Divisor load:
  - On div_load=1, div_val is captured into pend_div and pend_valid<=1.
  - If div_val<2, 2 is substituted and err<=1; err clears only on rst.
- Divisor apply:
  - pend_div is copied to cur_div at the next wrap edge while running, or at the next edge while not running, including the start edge.
  - div_ack is high for exactly the cycle following the apply edge.
  - pend_valid<=0 on apply.
- Load coincident with a wrap edge, or while stopped: the value applies at that same edge (bypass) and div_ack follows next cycle.
- Multiple loads before apply: last value wins, with a single div_ack.
- A load in the same cycle as rst is ignored.
- The new divisor never alters a period already in progress: no runt or stretched pulses except on en deassertion or rst.
- D=2^WIDTH-1 (e.g. 255 at WIDTH=8): high 128, low 127 cycles; the counter must not overflow.
- Latency: clk_out and tick are registered; the first high cycle is the cycle after en is sampled high.

Test Plan:
- Reset, DEFAULT_DIV=4, en=1 held: clk_out pattern 1,1,0,0 repeating; tick high on every 4th cycle aligned with the first 1; div_ack=0, err=0.
- Load D=5 while stopped, then en=1: div_ack pulses once; clk_out is 3 high / 2 low, period 5; tick period 5.
- Running at D=4, load D=6 at cnt=1: current period completes as 2 high / 2 low; div_ack in the first cycle of the new period; then 3 high / 3 low.
- Load D=1, then D=0: err=1 and stays 1; divider runs at D=2 (alternating 1,0); err clears only after rst.
- en dropped during the high phase at D=8: clk_out=0 in the next cycle; en reasserted: clk_out high for 4 cycles starting the cycle after, with tick=1 in the first.
- rst asserted with pend_valid=1 (D=7 pending) mid-period: all outputs 0; cur_div=DEFAULT_DIV; no div_ack after reset; WIDTH=8 with D=255 gives 128 high / 127 low.
